// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, in-order fetch queue and IF/ID register
// Define FETCH_PERF_EN to add delivered-instruction and bubble counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [31:0]   NOP       = 32'h0000_0013;
  localparam logic [PW:0]   DEPTH_CNT = DEPTH[PW:0];
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};

  logic [31:0]      pcf;
  logic [31:0]      q_pc   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_filled;
  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [PW-1:0]    head, fill, tail, drop_cnt;
  logic [PW-1:0]    alloc_cnt, pend_cnt, drop_after_flush;
  logic [AW-1:0]    head_idx, fill_idx, tail_idx;
  logic             req_fire, rsp_drop, rsp_fill, pop;

  assign alloc_cnt = tail - head;
  assign pend_cnt  = tail - fill;
  assign head_idx  = head[AW-1:0];
  assign fill_idx  = fill[AW-1:0];
  assign tail_idx  = tail[AW-1:0];

  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, alloc_cnt} + {1'b0, drop_cnt}) < DEPTH_CNT);
  assign imem_req_addr  = pcf;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (pend_cnt != '0);
  assign pop      = !redirect_valid && !stall_d && (alloc_cnt != '0) && q_filled[head_idx];

  // A response arriving with the redirect has already returned, so it is not re-counted.
  assign drop_after_flush = drop_cnt + pend_cnt - {{(PW-1){1'b0}}, rsp_drop | rsp_fill};

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf        <= RESET_PC;
      head       <= '0;
      fill       <= '0;
      tail       <= '0;
      drop_cnt   <= '0;
      valid_d    <= 1'b0;
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
    end else if (redirect_valid) begin
      pcf      <= redirect_pc & 32'hFFFF_FFFC;
      head     <= tail;
      fill     <= tail;
      drop_cnt <= drop_after_flush;
      valid_d  <= 1'b0;
      instr_d  <= NOP;
    end else begin
      if (req_fire) begin
        pcf  <= pcf + 32'd4;
        tail <= tail + PTR_ONE;
      end
      if (rsp_drop) drop_cnt <= drop_cnt - PTR_ONE;
      if (rsp_fill) fill <= fill + PTR_ONE;
      if (pop) begin
        head       <= head + PTR_ONE;
        valid_d    <= 1'b1;
        instr_d    <= q_data[head_idx];
        pc_d       <= q_pc[head_idx];
        pc_plus4_d <= q_pc[head_idx] + 32'd4;
      end else if (!stall_d) begin
        valid_d <= 1'b0;
        instr_d <= NOP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_filled <= '0;
    end else begin
      if (rsp_fill) begin
        q_filled[fill_idx] <= 1'b1;
        q_data[fill_idx]   <= imem_rsp_data;
      end
      if (req_fire) begin
        q_filled[tail_idx] <= 1'b0;
        q_pc[tail_idx]     <= pcf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid) assert (drop_cnt != '0 || pend_cnt != '0);
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_cnt, bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_cnt <= '0;
      bubble_cnt  <= '0;
    end else begin
      if (pop) fetched_cnt <= fetched_cnt + 32'd1;
      if (!redirect_valid && !stall_d && !pop) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign perf_fetched = fetched_cnt;
  assign perf_bubbles = bubble_cnt;
`else
  assign perf_fetched = '0;
  assign perf_bubbles = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a queue-level reference model
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall_d = 1'b0;
  logic        valid_d;
  logic [31:0] instr_d, pc_d, pc_plus4_d, perf_fetched, perf_bubbles;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_d(stall_d),
    .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Reference model: program-order list of allocated fetches plus a discard count.
  logic [31:0] m_qpc[$];
  bit          m_qfill[$];
  int          m_drop;
  logic [31:0] m_pcf, m_instr, m_pc, m_pc4, m_fetched, m_bubbles;
  bit          m_valid;

  // Instruction memory: in-order responses, each with a due cycle.
  logic [31:0] mem_data[$];
  int          mem_due[$];
  int          last_due = 0;
  int          cyc = 0;

  int p_ready = 100, lat_lo = 1, lat_hi = 1, p_stall = 0, p_redirect = 0;
  bit f_stall = 0, f_redir = 0;
  logic [31:0] f_redir_pc = '0;

  function automatic int m_unfilled();
    int n = 0;
    foreach (m_qfill[i]) if (!m_qfill[i]) n++;
    return n;
  endfunction

  task automatic model_step(input bit fire);
    bit head_ok, found;
    if (rst) begin
      m_qpc.delete(); m_qfill.delete();
      m_drop = 0; m_pcf = 32'h0;
      m_valid = 0; m_instr = NOP; m_pc = 0; m_pc4 = 0;
      m_fetched = 0; m_bubbles = 0;
      return;
    end
    head_ok = (m_qpc.size() > 0) && m_qfill[0];
    if (imem_rsp_valid) begin
      if (m_drop > 0) m_drop--;
      else begin
        found = 0;
        foreach (m_qfill[i]) if (!found && !m_qfill[i]) begin m_qfill[i] = 1; found = 1; end
        check("rsp_outstanding", 32'(found), 32'd1);
      end
    end
    if (redirect_valid) begin
      m_drop += m_unfilled();
      m_qpc.delete(); m_qfill.delete();
      m_pcf = {redirect_pc[31:2], 2'b00};
      m_valid = 0; m_instr = NOP;
      return;
    end
    if (!stall_d && head_ok) begin
      m_valid = 1; m_pc = m_qpc[0]; m_instr = mem_word(m_pc); m_pc4 = m_pc + 4;
      m_fetched++;
      void'(m_qpc.pop_front()); void'(m_qfill.pop_front());
    end else if (!stall_d) begin
      m_valid = 0; m_instr = NOP; m_bubbles++;
    end
    if (fire) begin
      m_qpc.push_back(m_pcf); m_qfill.push_back(0);
      m_pcf += 4;
    end
  endtask

  // One clock: drive at posedge+1, check requests at negedge, check IF/ID after next posedge.
  task automatic cycle();
    bit exp_req;
    int lat, due;
    imem_req_ready = int'($urandom_range(99)) < p_ready;
    stall_d        = f_stall || (int'($urandom_range(99)) < p_stall);
    redirect_valid = f_redir || (int'($urandom_range(99)) < p_redirect);
    redirect_pc    = f_redir ? f_redir_pc : $urandom;
    if (rst) begin
      mem_data.delete(); mem_due.delete(); last_due = cyc;
    end
    if (!rst && mem_due.size() > 0 && mem_due[0] <= cyc) begin
      imem_rsp_valid = 1; imem_rsp_data = mem_data[0];
      void'(mem_data.pop_front()); void'(mem_due.pop_front());
    end else begin
      imem_rsp_valid = 0; imem_rsp_data = $urandom;
    end
    @(negedge clk);
    exp_req = !rst && !redirect_valid && (m_qpc.size() + m_drop < DEPTH);
    check("imem_req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check("imem_req_addr", imem_req_addr, m_pcf);
    if (!rst && imem_req_valid && imem_req_ready) begin
      lat = int'($urandom_range(lat_hi, lat_lo));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      mem_data.push_back(mem_word(imem_req_addr)); mem_due.push_back(due);
      last_due = due;
    end
    model_step(exp_req && imem_req_ready);
    @(posedge clk); #1;
    cyc++;
    check("valid_d", 32'(valid_d), 32'(m_valid));
    check("instr_d", instr_d, m_instr);
    check("pc_d", pc_d, m_pc);
    check("pc_plus4_d", pc_plus4_d, m_pc4);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_bubbles", perf_bubbles, m_bubbles);
`else
    check("perf_fetched", perf_fetched, 32'h0);
    check("perf_bubbles", perf_bubbles, 32'h0);
`endif
  endtask

  task automatic do_reset();
    rst = 1; cycle(); cycle(); rst = 0;
  endtask

  initial begin
    int first, cnt;
    bit found;
    @(posedge clk); #1;

    // Reset, first fetch three cycles after the first request, then streaming.
    p_ready = 100; lat_lo = 1; lat_hi = 1;
    do_reset();
    first = -1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      if (valid_d && first < 0) begin
        first = i;
        check("first_instr", instr_d, 32'h0050_0093);
        check("first_pc_plus4", pc_plus4_d, 32'h4);
      end
    end
    check("first_latency", 32'(first), 32'd3);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin cycle(); cnt += int'(valid_d); end
    check("stream_run", 32'(cnt), 32'd8);

    // Stall while pc_d = 0x8.
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (valid_d && pc_d == 32'h8) found = 1;
    end
    check("stall_reach_pc8", 32'(found), 32'd1);
    f_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_hold_pc", pc_d, 32'h8);
      check("stall_hold_instr", instr_d, mem_word(32'h8));
    end
    f_stall = 0;
    cycle();
    check("after_stall_pc", pc_d, 32'hC);

    // Redirect with three requests in flight at L=3.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_unfilled() >= 3) found = 1;
      else cycle();
    end
    check("inflight_three", 32'(found), 32'd1);
    f_redir = 1; f_redir_pc = 32'h103;
    cycle();
    f_redir = 0;
    check("redirect_bubble", 32'(valid_d), 32'd0);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (valid_d) begin found = 1; check("redirect_first_pc", pc_d, 32'h100); end
    end
    check("redirect_delivered", 32'(found), 32'd1);

    // Backpressure for five cycles drains the queue into bubbles.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 10; i++) cycle();
    p_ready = 0;
    for (int i = 0; i < 5; i++) cycle();
    check("backpressure_bubble", 32'(valid_d), 32'd0);
    p_ready = 100;
    for (int i = 0; i < 6; i++) cycle();

    // Redirect and stall together: flush wins.
    f_stall = 1; f_redir = 1; f_redir_pc = 32'h40;
    cycle();
    f_stall = 0; f_redir = 0;
    check("flush_over_stall", 32'(valid_d), 32'd0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (valid_d) begin found = 1; check("flush_first_pc", pc_d, 32'h40); end
    end
    check("flush_delivered", 32'(found), 32'd1);

    // Randomized segments with varying ready, latency, stall and redirect rates.
    for (int seg = 0; seg < 15; seg++) begin
      p_ready    = int'($urandom_range(100, 30));
      lat_lo     = 1;
      lat_hi     = int'($urandom_range(4, 1));
      p_stall    = int'($urandom_range(40, 0));
      p_redirect = int'($urandom_range(8, 0));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(299) == 0) do_reset();
        else cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
